// File: rtl/integer_issue_arbiter.sv
// Oldest-first issue arbiter for the integer pipe: picks the minimum-age ready
// requester relative to rob_head and holds it in a single execute-stage register.
module integer_issue_arbiter #(
   parameter int N_REQ     = 4,
   parameter int PAYLOAD_W = 128,
   parameter int ROB_ID_W  = 6
) (
   input  logic                               clk,
   input  logic                               rst_aL,
   input  logic [N_REQ-1:0]                   req_valid,
   input  logic [N_REQ-1:0][ROB_ID_W-1:0]     req_rob_id,
   input  logic [N_REQ-1:0][PAYLOAD_W-1:0]    req_payload,
   input  logic [ROB_ID_W-1:0]                rob_head,
   output logic [N_REQ-1:0]                   grant,
   output logic                               ex_valid,
   output logic [ROB_ID_W-1:0]                ex_rob_id,
   output logic [PAYLOAD_W-1:0]               ex_payload,
   input  logic                               ex_ready,
   input  logic                               flush_valid,
   input  logic [ROB_ID_W-1:0]                flush_rob_id,
   output logic [15:0]                        grant_cnt
);

   // state    | meaning
   // ST_EMPTY | execute register holds nothing
   // ST_FULL  | execute register holds an instruction awaiting ex_ready
   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} ex_state_t;

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   ex_state_t                       state_q;
   ex_state_t                       state_d;
   logic [N_REQ-1:0][ROB_ID_W-1:0]  req_age;
   logic                            sel_found;
   logic [IDX_W-1:0]                sel_idx;
   logic [ROB_ID_W-1:0]             sel_age;
   logic                            can_accept;
   logic                            grant_any;
   logic [ROB_ID_W-1:0]             ex_age;
   logic [ROB_ID_W-1:0]             flush_age;
   logic                            flush_kill;

   always_comb begin
      req_age = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_age[i] = req_rob_id[i] - rob_head;
      end
   end

   // Strict less-than keeps the lowest index on equal age.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_age   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] && (!sel_found || (req_age[i] < sel_age))) begin
            sel_found = 1'b1;
            sel_idx   = i[IDX_W-1:0];
            sel_age   = req_age[i];
         end
      end
   end

   assign can_accept = (!ex_valid || ex_ready) && !flush_valid;
   assign grant_any  = sel_found && can_accept && rst_aL;

   always_comb begin
      grant = '0;
      if (grant_any) begin
         grant[sel_idx] = 1'b1;
      end
   end

   assign ex_age     = ex_rob_id - rob_head;
   assign flush_age  = flush_rob_id - rob_head;
   assign flush_kill = flush_valid && (ex_age > flush_age);

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (grant_any) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (grant_any) begin
               state_d = ST_FULL;
            end else if (flush_kill || ex_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      ex_valid = (state_q == ST_FULL);
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         ex_rob_id  <= '0;
         ex_payload <= '0;
      end else if (grant_any) begin
         ex_rob_id  <= req_rob_id[sel_idx];
         ex_payload <= req_payload[sel_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         grant_cnt <= '0;
      end else if (grant_any && (grant_cnt != 16'hFFFF)) begin
         grant_cnt <= grant_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_integer_issue_arbiter.sv
// Directed bench for integer_issue_arbiter: selection, wrap, backpressure,
// flush, saturation and asynchronous reset, with hand-computed expectations.
module tb_integer_issue_arbiter;

   localparam int N_REQ     = 4;
   localparam int PAYLOAD_W = 128;
   localparam int ROB_ID_W  = 6;

   logic                               clk;
   logic                               rst_aL;
   logic [N_REQ-1:0]                   req_valid;
   logic [N_REQ-1:0][ROB_ID_W-1:0]     req_rob_id;
   logic [N_REQ-1:0][PAYLOAD_W-1:0]    req_payload;
   logic [ROB_ID_W-1:0]                rob_head;
   logic [N_REQ-1:0]                   grant;
   logic                               ex_valid;
   logic [ROB_ID_W-1:0]                ex_rob_id;
   logic [PAYLOAD_W-1:0]               ex_payload;
   logic                               ex_ready;
   logic                               flush_valid;
   logic [ROB_ID_W-1:0]                flush_rob_id;
   logic [15:0]                        grant_cnt;

   int n_cmp = 0;
   int n_err = 0;

   integer_issue_arbiter #(
      .N_REQ     (N_REQ),
      .PAYLOAD_W (PAYLOAD_W),
      .ROB_ID_W  (ROB_ID_W)
   ) u_dut (
      .clk          (clk),
      .rst_aL       (rst_aL),
      .req_valid    (req_valid),
      .req_rob_id   (req_rob_id),
      .req_payload  (req_payload),
      .rob_head     (rob_head),
      .grant        (grant),
      .ex_valid     (ex_valid),
      .ex_rob_id    (ex_rob_id),
      .ex_payload   (ex_payload),
      .ex_ready     (ex_ready),
      .flush_valid  (flush_valid),
      .flush_rob_id (flush_rob_id),
      .grant_cnt    (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PAYLOAD_W-1:0] pay(input int idx);
      logic [31:0] w;
      w = 32'hA5A5_0000 + 32'(idx) * 32'h0001_1111;
      return {w, ~w, w ^ 32'h0F0F_0F0F, 32'(idx)};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_aL       = 1'b0;
      req_valid    = 4'b1111;
      req_rob_id   = '0;
      rob_head     = '0;
      ex_ready     = 1'b1;
      flush_valid  = 1'b0;
      flush_rob_id = '0;
      for (int i = 0; i < N_REQ; i++) req_payload[i] = pay(i);

      // reset state
      #3;
      chk("rst_grant", grant, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_payload", ex_payload, 0);
      chk("rst_cnt", grant_cnt, 0);
      req_valid = '0;
      #9 rst_aL = 1'b1;
      step();

      // oldest first
      rob_head = 6'd0;
      req_valid = 4'b1010;
      req_rob_id[1] = 6'd9;
      req_rob_id[3] = 6'd3;
      #1 chk("oldest_grant", grant, 4'b1000);
      step();
      chk("oldest_ex_valid", ex_valid, 1);
      chk("oldest_ex_rob_id", ex_rob_id, 3);
      chk("oldest_ex_payload", ex_payload, pay(3));
      chk("oldest_cnt", grant_cnt, 1);
      req_valid = '0;
      step();
      chk("drain_ex_valid", ex_valid, 0);

      // equal-age tie and wrap-around
      rob_head = 6'd62;
      req_valid = 4'b0101;
      req_rob_id[0] = 6'd5;
      req_rob_id[2] = 6'd5;
      #1 chk("tie_grant", grant, 4'b0001);
      req_valid = 4'b0011;
      req_rob_id[1] = 6'd1;
      #1 chk("wrap_grant", grant, 4'b0010);
      step();
      chk("wrap_ex_rob_id", ex_rob_id, 1);
      chk("wrap_cnt", grant_cnt, 2);

      // backpressure
      ex_ready = 1'b0;
      req_valid = 4'b0100;
      req_rob_id[2] = 6'd20;
      for (int c = 0; c < 3; c++) begin
         #1 chk("bp_grant", grant, 0);
         step();
         chk("bp_ex_payload", ex_payload, pay(1));
         chk("bp_ex_valid", ex_valid, 1);
      end
      ex_ready = 1'b1;
      #1 chk("bp_release_grant", grant, 4'b0100);
      step();
      chk("bp_new_rob_id", ex_rob_id, 20);
      chk("bp_new_payload", ex_payload, pay(2));
      chk("bp_cnt", grant_cnt, 3);

      // flush kill
      rob_head = 6'd0;
      req_valid = 4'b0001;
      req_rob_id[0] = 6'd10;
      step();
      chk("fk_load_rob_id", ex_rob_id, 10);
      req_rob_id[0] = 6'd2;
      flush_valid = 1'b1;
      flush_rob_id = 6'd7;
      #1 chk("fk_grant", grant, 0);
      step();
      chk("fk_ex_valid", ex_valid, 0);
      chk("fk_cnt", grant_cnt, 4);

      // flush keep
      flush_valid = 1'b0;
      req_rob_id[0] = 6'd4;
      step();
      chk("fkeep_load", ex_rob_id, 4);
      flush_valid = 1'b1;
      ex_ready = 1'b0;
      req_valid = 4'b0010;
      req_rob_id[1] = 6'd1;
      #1 chk("fkeep_grant", grant, 0);
      step();
      chk("fkeep_ex_valid", ex_valid, 1);
      chk("fkeep_ex_rob_id", ex_rob_id, 4);
      ex_ready = 1'b1;
      step();
      chk("fkeep_ready_clear", ex_valid, 0);
      #1 chk("flush_empty_grant", grant, 0);
      step();
      chk("flush_empty_cnt", grant_cnt, 5);

      // counter saturation
      flush_valid = 1'b0;
      req_valid = 4'b0001;
      req_rob_id[0] = 6'd9;
      repeat (65529) step();
      chk("cnt_fffe", grant_cnt, 16'hFFFE);
      repeat (11) step();
      chk("cnt_sat", grant_cnt, 16'hFFFF);

      // asynchronous reset mid-stall
      ex_ready = 1'b0;
      step();
      step();
      chk("stall_ex_valid", ex_valid, 1);
      #2 rst_aL = 1'b0;
      #1;
      chk("arst_ex_valid", ex_valid, 0);
      chk("arst_cnt", grant_cnt, 0);
      chk("arst_ex_rob_id", ex_rob_id, 0);
      chk("arst_grant", grant, 0);
      #1 rst_aL = 1'b1;
      #1 chk("post_rst_grant", grant, 4'b0001);
      step();
      chk("post_rst_ex_valid", ex_valid, 1);
      chk("post_rst_ex_rob_id", ex_rob_id, 9);
      chk("post_rst_cnt", grant_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
